axi_lite_reg_slave: RTL and testbench
=====================================

# axi_lite_reg_slave

AXI4-Lite responder endpoint that terminates one slave port of the AXI4-Lite interconnect and exposes a bank of 32-bit read/write registers. It accepts write address and write data independently and in either order, then returns a write response. It serves reads with one-cycle latency and flags out-of-range accesses. Register contents and per-register write pulses go to downstream logic.

## Interface
- `ADDR_W`, 32: address width.
- `NUM_REGS`, 4: number of 32-bit registers, ≥1; matches the 0x10-byte window per slave.
- `BASE_ADDR`, 32'h0: byte address of register 0.
- `aclk` in 1: clock.
- `areset` in 1: reset, synchronous, active-high.
- `awaddr` in ADDR_W; `awvalid` in 1; `awready` out 1: write address channel.
- `wdata` in 32; `wstrb` in 4; `wvalid` in 1; `wready` out 1: write data channel.
- `bresp` out 2; `bvalid` out 1; `bready` in 1: write response channel.
- `araddr` in ADDR_W; `arvalid` in 1; `arready` out 1: read address channel.
- `rdata` out 32; `rresp` out 2; `rvalid` out 1; `rready` in 1: read data channel.
- `reg_q` out NUM_REGS*32: register contents; register i is at bits [32i+31:32i].
- `reg_wr` out NUM_REGS: one-cycle pulse on the cycle after register i is written.

## Operation
- Decode: offset = addr − BASE_ADDR. The access is in range if BASE_ADDR ≤ addr < BASE_ADDR + 4·NUM_REGS. Index = offset[..:2]. Bits [1:0] are ignored.
- Write FSM states:
  - W_IDLE: awready=1 until AW is captured; wready=1 until W is captured. Each channel is captured independently into holding registers.
  - When both are held, including when both arrive in the same cycle: commit, then go to W_RESP.
  - Commit: for each byte b with wstrb[b]=1, reg[index][8b+7:8b] ← wdata[8b+7:8b]. If out of range, nothing is written.
  - W_RESP: bvalid=1, awready=wready=0. On bready, go to W_IDLE and clear the holding flags.
- Read FSM states:
  - R_IDLE: arready=1. On arvalid, latch rdata (reg[index], or 0 if out of range) and rresp, then go to R_DATA.
  - R_DATA: rvalid=1, arready=0. rdata and rresp hold stable until rready, then go to R_IDLE.
- The read and write FSMs are fully independent and may run concurrently.
- Same-register collision: a read whose AR handshake falls on the same edge as a write commit returns the pre-write value.
- bresp/rresp values: OKAY = 2'b00; SLVERR = 2'b10 (see Configuration).

## Timing
- Reset: on the first edge with areset=1:
  - FSMs go to their IDLE states; holding flags clear.
  - bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0.
  - All registers = 0; reg_wr = 0.
  - awready, wready, arready are forced to 0 while areset=1.
- Reset mid-transaction drops any pending AW, W, B or R with no response. A held bvalid or rvalid falls on the reset edge.
- Write latency: the last of the AW/W handshakes happens in cycle N. Then reg_q updates, bvalid=1 and reg_wr[index]=1 in cycle N+1.
- Back-to-back writes: bready=1 in N+1 gives W_IDLE in N+2. Sustained throughput is therefore one write per 2 cycles.
- Read latency: AR handshake in N gives rvalid in N+1. With rready held, throughput is one read per 2 cycles.
- Handshake rules:
  - Readies do not depend combinationally on valids.
  - bvalid and rvalid never drop without a ready.
  - Outputs change only on aclk edges.
- Address arithmetic is done at ADDR_W width with no wrap. An address below BASE_ADDR is out of range.

## Configuration
- `AXIL_REG_SLAVE_SLVERR_EN` defined: out-of-range reads return rdata=0 with rresp=SLVERR; out-of-range writes are dropped with bresp=SLVERR.
- Not defined: both cases return OKAY. Reads still return 0 and writes are still dropped.
- Handshake timing is identical in both builds.

## Structure
- `axi_lite_pkg` gains:
  - `axi_resp_t` enum: OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11.
  - Write and read state enums.
  - `AXI_DATA_W` = 32 and `AXI_STRB_W` = 4.
- One sub-module, `axi_lite_addr_decode`: combinational; given an address, returns in_range and index. It is instanced once for the write path and once for the read path.

## Test plan
- Reset, then AW=0x4 and W=0xDEADBEEF with strb=0xF in the same cycle → bvalid in the next cycle with bresp=OKAY and reg_wr[1]=1. A read of 0x4 then returns 0xDEADBEEF with OKAY, rvalid one cycle after AR.
- W (0x11223344, strb=0xF) sent 3 cycles before AW=0x8 → wready drops after capture; the commit happens only after AW. reg_q word 2 = 0x11223344.
- reg0 = 0xFFFFFFFF, then write 0x00000000 with strb=0x5 → reg0 = 0xFF00FF00.
- Read 0x20 (out of range, NUM_REGS=4) → rdata=0:
  - rresp=2'b10 when the macro is defined;
  - rresp=2'b00 when it is not.
- bready held low for 5 cycles → bvalid stays 1 and awready/wready stay 0. A concurrent read of 0x0 completes normally in the meantime.
- areset asserted while rvalid=1 and rready=0 → rvalid=0 and reg_q=0 after the edge; arready=1 on the first cycle after reset is released.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types for the register slave.
// Response codes, channel FSM states and bus widths.
package axi_lite_pkg;

  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Maps a byte address onto a register index within the slave window.
// Bits [1:0] are ignored; addresses below the base are out of range.
module axi_lite_addr_decode import axi_lite_pkg::*; #(
  parameter int                ADDR_W    = 32,
  parameter int                NUM_REGS  = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                IDX_W     = 2
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              in_range,
  output logic [IDX_W-1:0]  index
);

  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(4 * NUM_REGS);

  logic [ADDR_W-1:0] offset;

  // Compare the offset one bit wider so a window at the top of the map cannot wrap.
  assign offset   = addr - BASE_ADDR;
  assign in_range = (addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign index    = offset[IDX_W+1:2];

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank slave with independent read and write FSMs.
// Define AXIL_REG_SLAVE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi_lite_reg_slave import axi_lite_pkg::*; #(
  parameter int                ADDR_W    = 32,
  parameter int                NUM_REGS  = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [AXI_DATA_W-1:0]      wdata,
  input  logic [AXI_STRB_W-1:0]      wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  input  logic [ADDR_W-1:0]          araddr,
  input  logic                       arvalid,
  output logic                       arready,
  output logic [AXI_DATA_W-1:0]      rdata,
  output logic [1:0]                 rresp,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [NUM_REGS*32-1:0]     reg_q,
  output logic [NUM_REGS-1:0]        reg_wr
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AXIL_REG_SLAVE_SLVERR_EN
  localparam axi_resp_t OOR_RESP = SLVERR;
`else
  localparam axi_resp_t OOR_RESP = OKAY;
`endif

  wr_state_t             w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
  logic [AXI_DATA_W-1:0] wdata_q, wdata_d;
  logic [AXI_STRB_W-1:0] wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  axi_resp_t             bresp_q, bresp_d;
  logic [NUM_REGS-1:0]   reg_wr_q, reg_wr_d;
  logic [31:0]           regs_q [NUM_REGS];
  logic [31:0]           regs_d [NUM_REGS];

  rd_state_t             r_state_q, r_state_d;
  logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
  axi_resp_t             rresp_q, rresp_d;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_W-1:0]     wr_addr;
  logic [AXI_DATA_W-1:0] wr_data;
  logic [AXI_STRB_W-1:0] wr_strb;
  logic                  wr_in_range, rd_in_range;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  assign awready = !areset && (w_state_q == W_IDLE) && !aw_held_q;
  assign wready  = !areset && (w_state_q == W_IDLE) && !w_held_q;
  assign arready = !areset && (r_state_q == R_IDLE);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // A channel arriving this cycle bypasses its holding register.
  assign wr_addr = aw_held_q ? awaddr_q : awaddr;
  assign wr_data = w_held_q ? wdata_q : wdata;
  assign wr_strb = w_held_q ? wstrb_q : wstrb;
  assign commit  = (w_state_q == W_IDLE) &&
                   (aw_held_q || aw_hs) && (w_held_q || w_hs);

  axi_lite_addr_decode #(
    .ADDR_W    (ADDR_W),
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_wr_dec (
    .addr     (wr_addr),
    .in_range (wr_in_range),
    .index    (wr_idx)
  );

  axi_lite_addr_decode #(
    .ADDR_W    (ADDR_W),
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_rd_dec (
    .addr     (araddr),
    .in_range (rd_in_range),
    .index    (rd_idx)
  );

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    reg_wr_d  = '0;
    regs_d    = regs_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        if (commit) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = wr_in_range ? OKAY : OOR_RESP;
          if (wr_in_range) begin
            reg_wr_d[wr_idx] = 1'b1;
            for (int b = 0; b < AXI_STRB_W; b++) begin
              if (wr_strb[b]) begin
                regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
              end
            end
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Reads sample regs_q, so a same-edge commit is seen only by the next read.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          rdata_d   = rd_in_range ? regs_q[rd_idx] : '0;
          rresp_d   = rd_in_range ? OKAY : OOR_RESP;
        end
      end
      R_DATA: begin
        if (rready) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      reg_wr_q  <= '0;
      regs_q    <= '{default: '0};
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      reg_wr_q  <= reg_wr_d;
      regs_q    <= regs_d;
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign rvalid = (r_state_q == R_DATA);
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign reg_wr = reg_wr_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign reg_q[32*i +: 32] = regs_q[i];
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Testbench for axi_lite_reg_slave: vector table, corner sequences
// and random traffic checked against a word-array register model.
module tb_axi_lite_reg_slave;

  localparam int          NR   = 4;
  localparam logic [31:0] BASE = 32'h0;
`ifdef AXIL_REG_SLAVE_SLVERR_EN
  localparam logic [1:0]  OOR  = 2'b10;
`else
  localparam logic [1:0]  OOR  = 2'b00;
`endif

  logic          aclk, areset;
  logic [31:0]   awaddr, wdata, araddr, rdata;
  logic [3:0]    wstrb;
  logic          awvalid, awready, wvalid, wready;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, arvalid, arready, rvalid, rready;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0] reg_wr;

  axi_lite_reg_slave #(
    .ADDR_W    (32),
    .NUM_REGS  (NR),
    .BASE_ADDR (BASE)
  ) dut (
    .aclk    (aclk),
    .areset  (areset),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .reg_q   (reg_q),
    .reg_wr  (reg_wr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [NR];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: handshake timed out", name);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic bit m_in(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(4 * NR));
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [127:0] m_packed();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int awd, input int wd,
                           input logic [1:0] exp_resp);
    logic [NR-1:0] exp_wr;
    bit ap, wp, ha, hw;
    int t;
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    bready = 1'b0;
    ap = 1; wp = 1; t = 0;
    while ((ap || wp) && t < 30) begin
      awvalid = ap && (t >= awd);
      wvalid  = wp && (t >= wd);
      ha = awvalid && awready;
      hw = wvalid && wready;
      step();
      t++;
      if (ha) ap = 0;
      if (hw) wp = 0;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (ap || wp) begin
      timeout("write_aw_w");
      return;
    end
    exp_wr = '0;
    if (m_in(addr)) begin
      exp_wr[m_idx(addr)] = 1'b1;
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[m_idx(addr)][8*b +: 8] = data[8*b +: 8];
    end
    chk("bvalid_latency", bvalid, 1'b1);
    chk("bresp", bresp, exp_resp);
    chk("reg_wr_pulse", reg_wr, exp_wr);
    chk("reg_q_after_write", reg_q, m_packed());
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("bvalid_cleared", bvalid, 1'b0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_d,
                          input logic [1:0] exp_r, input int rwait);
    int t;
    araddr  = addr;
    arvalid = 1'b1;
    rready  = 1'b0;
    t = 0;
    while (!arready && t < 30) begin
      step();
      t++;
    end
    if (!arready) begin
      arvalid = 1'b0;
      timeout("read_ar");
      return;
    end
    step();
    arvalid = 1'b0;
    chk("rvalid_latency", rvalid, 1'b1);
    chk("rdata", rdata, exp_d);
    chk("rresp", rresp, exp_r);
    for (int k = 0; k < rwait; k++) begin
      step();
      chk("r_hold", {rvalid, rresp, rdata}, {1'b1, exp_r, exp_d});
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("rvalid_cleared", rvalid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, old;
    logic [3:0]  s;

    vt[0] = '{1'b1, 32'h4,  32'hDEADBEEF, 4'hF, 32'h0,        2'b00};
    vt[1] = '{1'b0, 32'h4,  32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
    vt[2] = '{1'b1, 32'h0,  32'hFFFFFFFF, 4'hF, 32'h0,        2'b00};
    vt[3] = '{1'b1, 32'h0,  32'h00000000, 4'h5, 32'h0,        2'b00};
    vt[4] = '{1'b0, 32'h0,  32'h0,        4'h0, 32'hFF00FF00, 2'b00};
    vt[5] = '{1'b0, 32'h20, 32'h0,        4'h0, 32'h0,        OOR};
    vt[6] = '{1'b1, 32'h10, 32'h12345678, 4'hF, 32'h0,        OOR};
    vt[7] = '{1'b0, 32'hC,  32'h0,        4'h0, 32'h0,        2'b00};
    vt[8] = '{1'b0, 32'h7,  32'h0,        4'h0, 32'hDEADBEEF, 2'b00};

    for (int i = 0; i < NR; i++) model[i] = '0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; araddr = '0; arvalid = 0; rready = 0;

    areset = 1'b1;
    step();
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    step();
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    chk("rst_resps", {bresp, rresp}, 4'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_reg_q", reg_q, 128'h0);
    chk("rst_reg_wr", reg_wr, 4'h0);
    areset = 1'b0;
    #1;
    chk("post_rst_readies", {awready, wready, arready}, 3'b111);

    for (int i = 0; i < 9; i++) begin
      if (vt[i].wr) axi_write(vt[i].addr, vt[i].data, vt[i].strb, 0, 0,
                              vt[i].exp_resp);
      else axi_read(vt[i].addr, vt[i].exp_data, vt[i].exp_resp, 0);
    end

    // W three cycles ahead of AW
    wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("wfirst_wready_drop", wready, 1'b0);
    chk("wfirst_awready", awready, 1'b1);
    step();
    step();
    chk("wfirst_no_commit", {bvalid, reg_q[95:64]}, {1'b0, model[2]});
    awaddr = 32'h8; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    model[2] = 32'h11223344;
    chk("wfirst_bvalid", bvalid, 1'b1);
    chk("wfirst_reg2", reg_q[95:64], 32'h11223344);
    chk("wfirst_reg_wr", reg_wr, 4'b0100);
    bready = 1'b1;
    step();
    bready = 1'b0;

    // bready stalled with a concurrent read
    awaddr = 32'hC; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    model[3] = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      chk("stall_bvalid", bvalid, 1'b1);
      chk("stall_readies", {awready, wready}, 2'b00);
      if (i == 0) begin
        chk("stall_arready", arready, 1'b1);
        araddr = 32'h0; arvalid = 1'b1;
      end
      if (i == 1) begin
        arvalid = 1'b0;
        chk("stall_rd_rvalid", rvalid, 1'b1);
        chk("stall_rd_rdata", rdata, model[0]);
        chk("stall_reg_wr_done", reg_wr, 4'h0);
        rready = 1'b1;
      end
      if (i == 2) begin
        rready = 1'b0;
        chk("stall_rd_done", rvalid, 1'b0);
      end
      step();
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("stall_released", {bvalid, awready}, 2'b01);

    // read and commit to reg1 on the same edge
    old = model[1];
    awaddr = 32'h4; wdata = 32'h0BADF00D; wstrb = 4'hF;
    araddr = 32'h4;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model[1] = 32'h0BADF00D;
    chk("coll_rdata_old", rdata, old);
    chk("coll_reg1_new", reg_q[63:32], 32'h0BADF00D);
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;

    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, 32'h17));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2),
                  m_in(a) ? 2'b00 : OOR);
      end else begin
        axi_read(a, m_in(a) ? model[m_idx(a)] : 32'h0,
                 m_in(a) ? 2'b00 : OOR, $urandom_range(0, 2));
      end
    end

    // reset while a read response is pending
    araddr = 32'h8; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk("mid_rst_rvalid_before", rvalid, 1'b1);
    areset = 1'b1;
    step();
    chk("mid_rst_rvalid", rvalid, 1'b0);
    chk("mid_rst_reg_q", reg_q, 128'h0);
    chk("mid_rst_arready", arready, 1'b0);
    areset = 1'b0;
    #1;
    chk("mid_rst_arready_after", arready, 1'b1);
    for (int i = 0; i < NR; i++) model[i] = '0;
    axi_read(32'h8, 32'h0, 2'b00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
